// File: rtl/interleaver_commutator.sv
// interleaver_commutator
// Commutator and sequencer for a convolutional byte interleaver. Each accepted
// byte is routed round-robin to branch 0..NUM_BRANCH-1. The branch pointer is
// locked to the packet sync byte. One-hot shift enables drive the external
// branch delay lines, and the selected branch tail (the value before the shift)
// is registered as the interleaved output.
// Optional feature macro: SYNC_ERR_CNT_EN adds an 8-bit saturating counter of
// sync_err pulses on port sync_err_cnt.
module interleaver_commutator #(
   parameter int NUM_BRANCH = 12,
   parameter int DEPTH      = 17,
   parameter int WIDTH      = 8,
   localparam int IDX_W     = (NUM_BRANCH > 1) ? $clog2(NUM_BRANCH) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_sync,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            br_data,
   output logic [NUM_BRANCH-1:0]       br_shift_en,
   input  logic [NUM_BRANCH*WIDTH-1:0] br_q,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_sync,
   input  logic                        out_ready,
   output logic [IDX_W-1:0]            branch_idx,
   output logic                        locked,
   output logic                        primed,
`ifdef SYNC_ERR_CNT_EN
   output logic [7:0]                  sync_err_cnt,
`endif
   output logic                        sync_err
);

   localparam int                PRIME_TARGET = NUM_BRANCH * (NUM_BRANCH - 1) * DEPTH;
   localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_BRANCH - 1);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_out_valid;
   logic [WIDTH-1:0]      r_out_data;
   logic                  r_out_sync;
   logic                  r_sync_err;
   logic                  r_primed;
   logic [15:0]           r_prime_cnt;

   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_take;
   logic                  w_resync;
   logic [IDX_W-1:0]      w_p;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [NUM_BRANCH-1:0] w_shift_en;
   logic [WIDTH-1:0]      w_tail;
   logic                  w_prime_hit;

   // The single output register may be refilled when it is empty or is being drained.
   assign w_in_ready = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;

   // Next-state logic: pick the branch for this byte and detect a resync.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_resync    = 1'b0;
      w_p         = r_idx;
      case (r_state)
         ST_SEARCH: begin
            if (w_accept && in_sync) begin
               w_take      = 1'b1;
               w_p         = '0;
               w_state_nxt = ST_RUN;
            end else begin
               w_take      = 1'b0;
            end
         end
         ST_RUN: begin
            if (w_accept) begin
               w_take = 1'b1;
               if (in_sync) begin
                  // A sync byte always belongs to branch 0. A sync seen at any other pointer forces the pointer back.
                  w_p      = '0;
                  w_resync = (r_idx != '0);
               end else begin
                  w_p      = r_idx;
               end
            end else begin
               w_take = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_SEARCH;
         end
      endcase
   end

   // Branch-side datapath: one-hot shift enable, tail select, and pointer advance.
   always_comb begin
      w_shift_en = '0;
      if (w_take && (w_p != '0)) begin
         w_shift_en[w_p] = 1'b1;
      end else begin
         w_shift_en = '0;
      end
      w_tail      = br_q[int'(w_p) * WIDTH +: WIDTH];
      w_idx_nxt   = (w_p == LAST_IDX) ? '0 : (w_p + IDX_W'(1));
      w_prime_hit = ((32'(r_prime_cnt) + 32'd1) >= 32'(PRIME_TARGET));
   end

   // Sequencer state, pointer, output register, sync error pulse and priming counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_SEARCH;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sync  <= 1'b0;
         r_sync_err  <= 1'b0;
         r_primed    <= 1'b0;
         r_prime_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_sync_err <= w_resync;
         if (w_take) begin
            r_idx       <= w_idx_nxt;
            r_out_valid <= 1'b1;
            r_out_data  <= (w_p == '0) ? in_data : w_tail;
            r_out_sync  <= in_sync;
            if (r_prime_cnt != 16'hFFFF) begin
               r_prime_cnt <= r_prime_cnt + 16'd1;
            end else begin
               r_prime_cnt <= r_prime_cnt;
            end
            r_primed    <= r_primed || w_prime_hit;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
      end
   end

`ifdef SYNC_ERR_CNT_EN
   logic [7:0] r_sync_err_cnt;

   // Saturating count of resync events. It rises together with the sync_err pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_err_cnt <= 8'd0;
      end else if (w_resync && (r_sync_err_cnt != 8'hFF)) begin
         r_sync_err_cnt <= r_sync_err_cnt + 8'd1;
      end else begin
         r_sync_err_cnt <= r_sync_err_cnt;
      end
   end

   assign sync_err_cnt = r_sync_err_cnt;
`endif

   assign in_ready    = w_in_ready;
   assign br_data     = in_data;
   assign br_shift_en = w_shift_en;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_sync    = r_out_sync;
   assign branch_idx  = r_idx;
   assign locked      = (r_state == ST_RUN);
   assign primed      = r_primed;
   assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_interleaver_commutator.sv
// Testbench for interleaver_commutator. Behavioural branch delay lines feed
// br_q. The reference model is a per-branch history of symbols: each output is
// the symbol that entered the same branch j*DEPTH branch-j symbols earlier, or
// zero if no such symbol exists yet.
module tb_interleaver_commutator;
   localparam int NB     = 12;
   localparam int DP     = 17;
   localparam int W      = 8;
   localparam int IW     = 4;
   localparam int TARGET = NB * (NB - 1) * DP;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_sync, in_ready;
   logic [W-1:0]    in_data, br_data;
   logic [NB-1:0]   br_shift_en;
   logic [NB*W-1:0] br_q;
   logic            out_valid, out_sync, out_ready;
   logic [W-1:0]    out_data;
   logic [IW-1:0]   branch_idx;
   logic            locked, primed, sync_err;
`ifdef SYNC_ERR_CNT_EN
   logic [7:0]      sync_err_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   interleaver_commutator #(.NUM_BRANCH(NB), .DEPTH(DP), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_sync(in_sync), .in_ready(in_ready), .br_data(br_data),
      .br_shift_en(br_shift_en), .br_q(br_q), .out_valid(out_valid),
      .out_data(out_data), .out_sync(out_sync), .out_ready(out_ready),
      .branch_idx(branch_idx), .locked(locked), .primed(primed),
`ifdef SYNC_ERR_CNT_EN
      .sync_err_cnt(sync_err_cnt),
`endif
      .sync_err(sync_err)
   );

   // External branch delay lines: branch j holds j*DP stages.
   logic [W-1:0] dl [NB][NB*DP];

   always @(posedge clk) begin
      for (int j = 0; j < NB; j++) begin
         if (reset) begin
            for (int k = 0; k < NB*DP; k++) dl[j][k] <= '0;
         end else if (j > 0 && br_shift_en[j]) begin
            for (int k = j*DP - 1; k > 0; k--) dl[j][k] <= dl[j][k-1];
            dl[j][0] <= br_data;
         end
      end
   end

   always_comb begin
      br_q = '0;
      for (int j = 1; j < NB; j++) br_q[j*W +: W] = dl[j][j*DP-1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model state.
   bit           m_locked, m_ov, m_os, m_se;
   int           m_p, m_cnt, m_secnt;
   logic [W-1:0] m_od;
   logic [W-1:0] hist [NB][$];

   task automatic model_step();
      bit rdy, acc;
      int b, n;
      if (reset) begin
         m_locked = 0; m_p = 0; m_ov = 0; m_od = '0; m_os = 0; m_se = 0;
         m_cnt = 0; m_secnt = 0;
         for (int j = 0; j < NB; j++) hist[j].delete();
      end else begin
         rdy  = !m_ov || out_ready;
         acc  = in_valid && rdy;
         m_se = 0;
         if (acc && (m_locked || in_sync)) begin
            b    = in_sync ? 0 : m_p;
            m_se = in_sync && m_locked && (m_p != 0);
            if (m_se && m_secnt < 255) m_secnt++;
            n = hist[b].size();
            hist[b].push_back(in_data);
            m_od = (n >= b*DP) ? hist[b][n - b*DP] : '0;
            m_ov = 1; m_os = in_sync; m_locked = 1;
            m_p  = (b + 1) % NB;
            if (m_cnt < 65535) m_cnt++;
         end else if (out_ready) begin
            m_ov = 0;
         end
      end
   endtask

   task automatic compare_all();
      bit rdy, acc;
      int b;
      logic [NB-1:0] e_sh;
      rdy  = !m_ov || out_ready;
      acc  = in_valid && rdy;
      b    = in_sync ? 0 : m_p;
      e_sh = '0;
      if (acc && (m_locked || in_sync) && b != 0) e_sh[b] = 1'b1;
      chk("in_ready", in_ready, rdy);
      chk("br_shift_en", br_shift_en, e_sh);
      chk("br_data", br_data, in_data);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_sync", out_sync, m_os);
      chk("branch_idx", branch_idx, m_p);
      chk("locked", locked, m_locked);
      chk("primed", primed, m_cnt >= TARGET);
      chk("sync_err", sync_err, m_se);
`ifdef SYNC_ERR_CNT_EN
      chk("sync_err_cnt", sync_err_cnt, m_secnt);
`endif
   endtask

   // Single compare process: advance the model at the edge and check at the falling edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         compare_all();
      end
   end

   task automatic set_in(input bit v, input bit s, input logic [W-1:0] d, input bit r);
      in_valid = v; in_sync = s; in_data = d; out_ready = r;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [NB-1:0] e;
      int guard;
      reset = 1'b1;
      set_in(0, 0, 8'h00, 1);
      step(); step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_primed", primed, 0);
      chk("rst_shift", br_shift_en, 0);
      chk("rst_idx", branch_idx, 0);
      reset = 1'b0;

      // SEARCH drops non-sync bytes.
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 8'h11, 1);
         chk("search_shift", br_shift_en, 0);
         step();
         chk("search_out_valid", out_valid, 0);
         chk("search_locked", locked, 0);
      end

      // Lock on the sync byte, then stream 0x01..0x17.
      set_in(1, 1, 8'h47, 1);
      chk("sync_shift", br_shift_en, 0);
      step();
      chk("sync_out_data", out_data, 8'h47);
      chk("sync_out_sync", out_sync, 1);
      chk("sync_locked", locked, 1);
      chk("sync_idx", branch_idx, 1);
      for (int k = 1; k <= 23; k++) begin
         set_in(1, 0, W'(k), 1);
         e = '0;
         if (k % NB != 0) e[k % NB] = 1'b1;
         chk("seq_shift", br_shift_en, e);
         step();
         if (k == 11) chk("wrap_idx", branch_idx, 0);
         if (k == 12) chk("br0_pass", out_data, 8'h0C);
      end

      // Backpressure: hold for 3 cycles.
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 8'h55, 0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_shift", br_shift_en, 0);
         step();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_data", out_data, 8'h00);
         chk("bp_idx", branch_idx, 0);
      end
      set_in(1, 0, 8'h55, 1);
      chk("bp_resume_ready", in_ready, 1);
      step();
      chk("bp_resume_data", out_data, 8'h55);
      chk("bp_resume_idx", branch_idx, 1);

      // Advance to pointer 5, then send an off-branch sync.
      guard = 0;
      while (m_p != 5 && guard < 50) begin
         set_in(1, 0, W'($urandom), 1);
         step();
         guard++;
      end
      chk("reach_p5", m_p, 5);
      set_in(1, 1, 8'hA5, 1);
      chk("resync_shift", br_shift_en, 0);
      step();
      chk("resync_err", sync_err, 1);
      chk("resync_data", out_data, 8'hA5);
      chk("resync_idx", branch_idx, 1);
`ifdef SYNC_ERR_CNT_EN
      chk("resync_cnt", sync_err_cnt, 1);
`endif
      set_in(1, 0, 8'h3C, 1);
      step();
      chk("resync_err_pulse", sync_err, 0);

      // Random stream until the delay lines are primed and well beyond.
      guard = 0;
      while (m_cnt < TARGET + 400 && guard < 30000) begin
         set_in($urandom_range(0, 9) < 8, ((m_p == 0) && ($urandom_range(0, 7) == 0)) ||
                ($urandom_range(0, 999) == 0),
                W'($urandom), $urandom_range(0, 9) < 8);
         step();
         guard++;
      end
      chk("stream_bound", guard < 30000, 1);
      chk("stream_primed", primed, 1);

      // Reset mid-operation.
      reset = 1'b1;
      set_in(1, 0, 8'h77, 1);
      step();
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_primed", primed, 0);
      chk("mid_rst_idx", branch_idx, 0);
      reset = 1'b0;
      set_in(0, 0, 8'h00, 1);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/interleaver_commutator.md
Name: interleaver_commutator

Overview:
Commutator and sequencer for the convolutional byte interleaver. It routes each accepted input byte to branch 0..NUM_BRANCH-1 in round-robin order and drives one-hot shift enables to the external branch delay lines. Branch j is a chain of j*DEPTH byte registers; branch 0 has no delay line. The block reads the selected branch tail back to form the interleaved output stream, locks the branch pointer to the packet sync byte, and tracks pipeline priming.

Parameters:
- NUM_BRANCH, 12, number of interleaver branches (at least 2).
- DEPTH, 17, register-stage increment per branch; branch j has j*DEPTH stages.
- WIDTH, 8, symbol width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input symbol valid.
- in_data  in  WIDTH  input symbol.
- in_sync  in  1  marks the packet sync byte; qualified by in_valid.
- in_ready  out  1  input accept; a transfer occurs when in_valid && in_ready.
- br_data  out  WIDTH  symbol broadcast to all branch inputs (equals in_data).
- br_shift_en  out  NUM_BRANCH  one-hot shift enable; bit 0 is always 0.
- br_q  in  NUM_BRANCH*WIDTH  branch tails; slice j is the last stage of branch j; slice 0 is ignored.
- out_valid  out  1  output symbol valid.
- out_data  out  WIDTH  interleaved symbol.
- out_sync  out  1  output symbol came from a sync input.
- out_ready  in  1  downstream accept.
- branch_idx  out  ceil(log2(NUM_BRANCH))  current branch pointer.
- locked  out  1  state is RUN.
- primed  out  1  all branch delay lines hold valid data.
- sync_err  out  1  one-cycle pulse when a sync arrives off branch 0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sync=0, br_shift_en=0, branch_idx=0, locked=0, primed=0, sync_err=0, state=SEARCH, prime counter=0.
- A reset asserted mid-operation returns the block to these values on the next edge. The external delay lines share the same reset.
- in_ready = !out_valid || out_ready. This is a combinational skid-free single output register.
- accept = in_valid && in_ready. br_data = in_data, combinational.

State SEARCH:
- Accepted bytes with in_sync=0 are dropped: no shift, no output.
- An accepted byte with in_sync=1 is handled as a RUN byte on branch 0. The state moves to RUN and branch_idx becomes 1.

State RUN, per accepted byte with pointer p:
- If in_sync=1 and p!=0: sync_err pulses next cycle, p is forced to 0 for this byte (resync), and the state stays RUN.
- If p=0: out_data <= in_data. br_shift_en stays 0.
- If p>0: br_shift_en[p]=1 combinationally in the accept cycle, and out_data <= br_q[p] sampled at the same edge (the pre-shift tail).
- out_valid <= 1 and out_sync <= in_sync.
- Next pointer is p+1, wrapping NUM_BRANCH-1 -> 0.

No-accept cycles:
- If out_ready is high, out_valid clears.
- br_shift_en is 0; pointer and output are held.

Latency and timing:
- Input to output is 1 cycle.
- Branch j total delay is j*DEPTH accepted branch-j symbols.

Priming:
- A 16-bit counter counts accepted bytes in RUN and saturates.
- primed=1 once the count reaches NUM_BRANCH*(NUM_BRANCH-1)*DEPTH (2244 at defaults).
- Resync does not clear the counter or primed; only reset does.

Optional Feature:
SYNC_ERR_CNT_EN
- Defined: adds output sync_err_cnt (8 bits, reset 0). It increments on each sync_err pulse and saturates at 255.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Apply reset for 2 cycles -> in_ready=1, out_valid=0, locked=0, primed=0, br_shift_en=0.
2. In SEARCH, send 5 bytes of 0x11 with in_sync=0 -> all accepted; out_valid stays 0; br_shift_en stays 0; locked stays 0.
3. Send sync 0x47, then bytes 0x01..0x17 with out_ready=1 held:
   - out_data for the 0x47 byte is 0x47 with out_sync=1.
   - br_shift_en sequence is 0, 2, 4, ... 0x800, 0, 2, ...
   - branch_idx wraps 11 -> 0 after the 12th byte.
4. With out_valid=1, drop out_ready for 3 cycles -> in_ready=0, br_shift_en=0, out_data and branch_idx held. Restore out_ready -> flow resumes with no lost or duplicated byte.
5. Assert in_sync at branch_idx=5 -> sync_err pulses 1 cycle, the byte is routed to branch 0 (out_data=in_data), and branch_idx becomes 1. With SYNC_ERR_CNT_EN, sync_err_cnt goes 0 -> 1.
6. Stream 2244 bytes after lock into behavioural delay lines -> primed rises on the cycle after the 2244th accept. Output matches a reference convolutional interleaver model (I=12, M=17) byte-for-byte.
